// File: rtl/sysid_probe_pkg.sv
// sysid_probe_pkg: shared FSM states, Avalon word addresses and stall-counter width
// for the system-ID probe master.
package sysid_probe_pkg;
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_e;
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
    localparam int STALL_W = 8;
endpackage

// File: rtl/sysid_probe_timer.sv
// sysid_probe_timer: per-read stall counter; expired holds once the count reaches limit.
module sysid_probe_timer import sysid_probe_pkg::*; (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [STALL_W-1:0] limit,
    output logic               expired
);
    logic [STALL_W-1:0] cnt_q, cnt_d;
    assign expired = (cnt_q >= limit);
    always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sysid_probe_master.sv
// sysid_probe_master: reads system ID and build timestamp over Avalon-MM and flags matches.
// Define SYSID_PROBE_TIMEOUT_EN to build in the per-read stall timeout.
module sysid_probe_master import sysid_probe_pkg::*; #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5135_046F,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);
    state_e      state_q, state_d;
    logic        read_q, read_d, addr_q, addr_d, done_q, done_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, tmo_q, tmo_d;
    logic [31:0] cid_q, cid_d, cts_q, cts_d;
    logic        expired;
`ifdef SYSID_PROBE_TIMEOUT_EN
    logic stall;
    assign stall = read_q & avm_waitrequest;
    sysid_probe_timer u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (~stall),
        .enable  (stall),
        .limit   (STALL_W'(TIMEOUT_CYCLES)),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        id_ok_d = id_ok_q;
        ts_ok_d = ts_ok_q;
        tmo_d   = tmo_q;
        cid_d   = cid_q;
        cts_d   = cts_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RD_ID;
                id_ok_d = 1'b0;
                ts_ok_d = 1'b0;
                tmo_d   = 1'b0;
                cid_d   = '0;
                cts_d   = '0;
            end
            RD_ID: if (!avm_waitrequest) begin
                cid_d   = avm_readdata;
                id_ok_d = (avm_readdata == EXPECTED_ID);
                state_d = RD_TS;
            end else if (expired) begin
                tmo_d   = 1'b1;
                state_d = FIN;
            end
            RD_TS: if (!avm_waitrequest) begin
                cts_d   = avm_readdata;
                ts_ok_d = (avm_readdata == EXPECTED_TS);
                state_d = FIN;
            end else if (expired) begin
                tmo_d   = 1'b1;
                state_d = FIN;
            end
            default: state_d = IDLE;
        endcase
        // bus strobes are registered from the next state so they hold through stalls
        read_d = (state_d == RD_ID) || (state_d == RD_TS);
        addr_d = (state_d == RD_TS) ? ADDR_TS : ADDR_ID;
        done_d = (state_d == FIN);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            done_q  <= 1'b0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            tmo_q   <= 1'b0;
            cid_q   <= '0;
            cts_q   <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            id_ok_q <= id_ok_d;
            ts_ok_q <= ts_ok_d;
            tmo_q   <= tmo_d;
            cid_q   <= cid_d;
            cts_q   <= cts_d;
        end
    end
    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = read_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = tmo_q;
    assign captured_id = cid_q;
    assign captured_ts = cts_q;
endmodule

// File: tb/tb_sysid_probe_master.sv
// tb_sysid_probe_master: table-driven probe sequences against a wait-state slave model,
// with a done-driven scoreboard plus hand-written busy-start and mid-read reset cases.
module tb_sysid_probe_master;
    localparam logic [31:0] TS = 32'h5135_046F;
`ifdef SYSID_PROBE_TIMEOUT_EN
    localparam int TMO = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO = 16;
    localparam bit TMO_EN = 1'b0;
`endif
    logic        clock, reset_n, start;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] captured_id, captured_ts;

    sysid_probe_master #(
        .EXPECTED_ID    (32'h0000_0000),
        .EXPECTED_TS    (TS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .captured_id     (captured_id),
        .captured_ts     (captured_ts)
    );

    typedef struct {
        logic [31:0] idd, tsd;
        int          idw, tsw;
        bit          idm, tsm;
    } vec_t;
    typedef struct {
        bit          id_ok, ts_ok, tmo;
        logic [31:0] cid, cts;
        int          lat, st;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0, nerr = 0, cyc = 0, done_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // slave: stalls s_idw / s_tsw cycles on each read, then returns data
    logic [31:0] s_idd = '0, s_tsd = '0;
    int          s_idw = 0, s_tsw = 0, wcnt = 0;
    logic        last_addr = 1'b0;
    initial begin
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
    end
    always @(negedge clock) begin
        if (!avm_read || avm_address != last_addr) wcnt = 0;
        last_addr = avm_address;
        if (avm_read && wcnt < (avm_address ? s_tsw : s_idw)) begin
            avm_waitrequest = 1'b1;
            wcnt++;
        end else begin
            avm_waitrequest = 1'b0;
            avm_readdata    = avm_address ? s_tsd : s_idd;
        end
    end

    // monitor: bus hold during stalls, single-cycle done, scoreboard on done
    logic p_stall = 1'b0, p_read = 1'b0, p_addr = 1'b0, p_done = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        #1;
        if (!reset_n) begin
            p_stall = 1'b0;
            p_done  = 1'b0;
        end else begin
            if (p_stall && !timeout) check("hold", {avm_read, avm_address}, {p_read, p_addr});
            if (p_stall && timeout) check("read_drop", avm_read, 1'b0);
            if (done) begin
                done_cnt++;
                check("done_pulse", p_done, 1'b0);
                if (sb.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
                end else begin
                    e = sb.pop_front();
                    check("id_ok", id_ok, e.id_ok);
                    check("ts_ok", ts_ok, e.ts_ok);
                    check("timeout", timeout, e.tmo);
                    check("captured_id", captured_id, e.cid);
                    check("captured_ts", captured_ts, e.cts);
                    check("latency", cyc - e.st, e.lat);
                    check("busy_fin", busy, 1'b0);
                end
            end
            p_stall = avm_read && avm_waitrequest;
            p_read  = avm_read;
            p_addr  = avm_address;
            p_done  = done;
        end
    end

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        bit idto, tsto;
        idto    = TMO_EN && v.idw > TMO;
        tsto    = TMO_EN && !idto && v.tsw > TMO;
        e.tmo   = idto || tsto;
        e.id_ok = v.idm && !idto;
        e.ts_ok = v.tsm && !idto && !tsto;
        e.cid   = idto ? 32'h0 : v.idd;
        e.cts   = (idto || tsto) ? 32'h0 : v.tsd;
        e.lat   = idto ? TMO + 2 : tsto ? v.idw + TMO + 3 : v.idw + v.tsw + 3;
        e.st    = 0;
        return e;
    endfunction

    task automatic launch(input vec_t v);
        exp_t e;
        @(negedge clock);
        s_idd = v.idd;
        s_tsd = v.tsd;
        s_idw = v.idw;
        s_tsw = v.tsw;
        start = 1'b1;
        e     = mk_exp(v);
        e.st  = cyc;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clock);
        #2;
        if (done_cnt == d0) begin
            ncmp++;
            nerr++;
            $display("FAIL no_done: got no done within 400 cycles expected one");
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, {avm_address, avm_read, busy, done, id_ok, ts_ok, timeout, captured_id, captured_ts}, 128'h0);
    endtask

    vec_t vt[9];
    initial begin
        int d0;
        vt[0] = '{32'h0000_0000, TS,            0,  0, 1'b1, 1'b1};
        vt[1] = '{32'h0000_0001, TS,            0,  0, 1'b0, 1'b1};
        vt[2] = '{32'h0000_0000, 32'h0,         0,  0, 1'b1, 1'b0};
        vt[3] = '{32'hDEAD_BEEF, 32'h5135_046E, 1,  2, 1'b0, 1'b0};
        vt[4] = '{32'h0000_0000, TS,            5,  5, 1'b1, 1'b1};
        vt[5] = '{32'h0000_0000, TS,            4,  4, 1'b1, 1'b1};
        vt[6] = '{32'hFFFF_FFFF, TS,            2,  0, 1'b0, 1'b1};
        vt[7] = '{32'h0000_0000, TS,            0, 60, 1'b1, 1'b1};
        vt[8] = '{32'h0000_0000, TS,           17,  3, 1'b1, 1'b1};
        start   = 1'b0;
        reset_n = 1'b0;
        #13;
        check_all_zero("reset_outs");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        #2;
        check_all_zero("idle_outs");
        for (int i = 0; i < 9; i++) begin
            d0 = done_cnt;
            launch(vt[i]);
            wait_done(d0);
        end
        // start pulses in RD_ID and in FIN must be ignored
        d0 = done_cnt;
        launch(vt[4]);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            @(negedge clock);
            #2;
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        d0 = done_cnt;
        repeat (8) @(negedge clock);
        #2;
        check("no_extra_done", done_cnt, d0);
        check("idle_busy", busy, 1'b0);
        // second start in RD_ID, then asynchronous reset in RD_TS
        launch('{32'h0000_0000, TS, 0, 10, 1'b1, 1'b1});
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #2;
        check("rd_ts_addr", {avm_read, avm_address}, 2'b11);
        check("id_ok_pre_rst", id_ok, 1'b1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        @(negedge clock);
        #1;
        check_all_zero("reset_hold");
        reset_n = 1'b1;
        d0 = done_cnt;
        repeat (4) @(negedge clock);
        #2;
        check("post_rst_idle", {busy, avm_read, done_cnt == d0}, 3'b001);
        d0 = done_cnt;
        launch(vt[0]);
        wait_done(d0);
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/sysid_probe_master.md
SYSID_PROBE_MASTER -- requirements
Module: sysid_probe_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock is `clock` and reset is `reset_n`, matching the codebase port names.
REQ-002 Parameter EXPECTED_ID, default 32'h0000_0000, is the system ID value the probe expects at word 0.
REQ-003 Parameter EXPECTED_TS, default 32'h5135_046F, is the build timestamp the probe expects at word 1.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of stalled cycles allowed per read (range 1..255).
REQ-005 clock  in  1  system clock; all state changes on the rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to run one probe sequence.
REQ-008 avm_address  out  1  Avalon-MM word address: 0 = ID, 1 = timestamp.
REQ-009 avm_read  out  1  Avalon-MM read strobe.
REQ-010 avm_waitrequest  in  1  slave stall; a read completes on the edge where avm_read=1 and avm_waitrequest=0.
REQ-011 avm_readdata  in  32  read data, sampled on the completing edge.
REQ-012 busy  out  1  a sequence is in progress.
REQ-013 done  out  1  one-cycle pulse at the end of every sequence, whether it passed, failed or timed out.
REQ-014 id_ok, ts_ok, timeout  out  1 each  sticky result flags, valid from done until the next accepted start.
REQ-015 captured_id, captured_ts  out  32 each  last values read.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_ID, RD_TS and FIN.
REQ-017 In IDLE with start=1, next state SHALL be RD_ID; all result flags and captures SHALL clear on that edge.
REQ-018 In RD_ID: avm_read=1 and avm_address=0; on the completing edge, captured_id<=avm_readdata, id_ok<=(avm_readdata==EXPECTED_ID), next state RD_TS.
REQ-019 In RD_TS: avm_read=1 and avm_address=1; on the completing edge, captured_ts<=avm_readdata, ts_ok<=(avm_readdata==EXPECTED_TS), next state FIN.
REQ-020 In FIN: done=1 for exactly one cycle, then IDLE; busy SHALL be 1 in RD_ID and RD_TS only.
REQ-021 avm_read and avm_address SHALL be registered and SHALL stay stable while avm_waitrequest=1.
REQ-022 Minimum latency with zero wait states: start edge to done high SHALL be 3 cycles (RD_ID, RD_TS, FIN).
REQ-023 start while busy or in FIN SHALL be ignored; a start in the same cycle that IDLE is re-entered SHALL be accepted.
REQ-024 A per-read stall counter SHALL clear on entry to each RD state and increment each cycle with avm_waitrequest=1.
REQ-025 When the stall counter reaches TIMEOUT_CYCLES, the FSM SHALL set timeout=1, leave the unfinished ok flag at 0, drop avm_read on the next edge and go to FIN.
REQ-026 A completion on the same edge that the counter reaches the limit SHALL count as a completion, not a timeout.

Reset
REQ-027 While reset_n=0, every output SHALL be 0 and the state SHALL be IDLE, asynchronously, including mid-read.
REQ-028 After reset deassertion, the block SHALL wait in IDLE for start.

Configuration
REQ-029 Macro SYSID_PROBE_TIMEOUT_EN SHALL compile the stall counter and timeout logic in.
REQ-030 With SYSID_PROBE_TIMEOUT_EN defined, behaviour is as in REQ-024..026.
REQ-031 Without SYSID_PROBE_TIMEOUT_EN, the block SHALL wait indefinitely for avm_waitrequest=0, the timeout output SHALL be tied to 0, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-032 Package sysid_probe_pkg SHALL hold the FSM state enum, the ID/TS word-address constants and the stall-counter width constant (8).
REQ-033 The stall counter SHALL be a sub-module, sysid_probe_timer (clear, enable, limit in; expired out), instantiated only under SYSID_PROBE_TIMEOUT_EN.

Verification
REQ-034 Zero-wait slave returns 0 and then 32'h5135_046F -> done at cycle 3; id_ok=1, ts_ok=1, timeout=0.
REQ-035 Slave returns ID 32'h0000_0001 -> id_ok=0, ts_ok=1, captured_id=1.
REQ-036 avm_waitrequest=1 for 5 cycles on each read -> address and read held stable; done at cycle 13; both ok flags set.
REQ-037 With the macro defined and TIMEOUT_CYCLES=4, waitrequest is stuck at 1 in RD_TS -> timeout=1, ts_ok=0, avm_read low one cycle later, and one done pulse.
REQ-038 start pulsed during RD_ID, then reset_n pulled low during RD_TS -> the second start has no effect; all outputs go to 0 immediately; a new start after release runs a clean sequence.
